// File: rtl/zatvaranje_stepper.sv
// Capping-head stepper controller: one lower / hold / return stroke per bottle
// sensed at the closing station, sequenced inside the conveyor stop window.
module zatvaranje_stepper #(
  parameter logic [31:0] step_delay      = 32'd200_000,
  parameter logic [31:0] debounce_cycles = 32'd500_000,
  parameter logic [31:0] settle_cycles   = 32'd12_500_000,
  parameter logic [15:0] cap_steps       = 16'd400,
  parameter logic [31:0] hold_cycles     = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_zatvaranje,
  output logic [3:0] motor_zatvaranje,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DEBOUNCE   = 3'd1,
    S_SETTLE     = 3'd2,
    S_DOWN       = 3'd3,
    S_HOLD       = 3'd4,
    S_UP         = 3'd5,
    S_WAIT_CLEAR = 3'd6
  } state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [15:0] steps_q;
  logic [1:0]  phase_q;
  logic [3:0]  motor_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] cnt_d;
  logic [15:0] steps_d;
  logic [1:0]  phase_inc_d;
  logic [1:0]  phase_dec_d;

  function automatic logic [3:0] phase_pattern(input logic [1:0] p);
    logic [3:0] pat;
    case (p)
      2'd0:    pat = 4'b1100;
      2'd1:    pat = 4'b0110;
      2'd2:    pat = 4'b0011;
      2'd3:    pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
    return pat;
  endfunction

  assign cnt_d       = cnt_q + 32'd1;
  assign steps_d     = steps_q + 16'd1;
  assign phase_inc_d = phase_q + 2'd1;
  assign phase_dec_d = phase_q - 2'd1;

  // Sequencer; phase_q is only cleared by rst so the head returns to its starting phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      steps_q <= 16'd0;
      phase_q <= 2'd0;
      motor_q <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          motor_q <= 4'b0000;
          cnt_q   <= 32'd0;
          steps_q <= 16'd0;
          if (!ir_zatvaranje) begin
            state_q <= S_DEBOUNCE;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_DEBOUNCE: begin
          if (ir_zatvaranje) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 32'd0;
          end else if (cnt_q >= debounce_cycles) begin
            state_q <= S_SETTLE;
            cnt_q   <= 32'd0;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        S_SETTLE: begin
          motor_q <= 4'b0000;
          if (cnt_q >= settle_cycles) begin
            state_q <= S_DOWN;
            cnt_q   <= 32'd0;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        S_DOWN: begin
          if (cnt_q >= step_delay) begin
            cnt_q   <= 32'd0;
            phase_q <= phase_inc_d;
            motor_q <= phase_pattern(phase_inc_d);
            if (steps_d == cap_steps) begin
              steps_q <= 16'd0;
              state_q <= S_HOLD;
            end else begin
              steps_q <= steps_d;
            end
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        S_HOLD: begin
          if (cnt_q >= hold_cycles) begin
            state_q <= S_UP;
            cnt_q   <= 32'd0;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        S_UP: begin
          if (cnt_q >= step_delay) begin
            cnt_q   <= 32'd0;
            phase_q <= phase_dec_d;
            motor_q <= phase_pattern(phase_dec_d);
            if (steps_d == cap_steps) begin
              steps_q <= 16'd0;
              state_q <= S_WAIT_CLEAR;
              done_q  <= 1'b1;
            end else begin
              steps_q <= steps_d;
            end
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        S_WAIT_CLEAR: begin
          // Exit once the sensor has read "clear" on debounce_cycles consecutive samples.
          motor_q <= 4'b0000;
          if (ir_zatvaranje) begin
            if (cnt_d >= debounce_cycles) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              cnt_q   <= 32'd0;
            end else begin
              cnt_q   <= cnt_d;
            end
          end else begin
            cnt_q   <= 32'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 32'd0;
          steps_q <= 16'd0;
          motor_q <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign motor_zatvaranje = motor_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
